// File: rtl/agent_scheduler_if.sv
// agent_scheduler_if: handshake bundle between the scheduler, sensor front-end, AGENT datapath and light driver.
interface agent_scheduler_if #(
   parameter int L_WIDTH    = 4,
   parameter int STEP_WIDTH = 16
);
   localparam int A_WIDTH = 2 + L_WIDTH / 2;
   logic                  start;
   logic                  stop;
   logic                  learn;
   logic [STEP_WIDTH-1:0] max_step;
   logic [7:0]            epsilon;
   logic                  sensor_valid;
   logic [A_WIDTH-1:0]    A;
   logic                  A_sel;
   logic                  mode;
   logic                  agent_en;
   logic                  q_wr;
   logic                  light_go;
   logic [A_WIDTH-1:0]    a_hold;
   logic [STEP_WIDTH-1:0] step_cnt;
   logic                  busy;
   logic                  done;
   modport master (
      output start, stop, learn, max_step, epsilon, sensor_valid, A,
      input  A_sel, mode, agent_en, q_wr, light_go, a_hold, step_cnt, busy, done
   );
   modport slave (
      input  start, stop, learn, max_step, epsilon, sensor_valid, A,
      output A_sel, mode, agent_en, q_wr, light_go, a_hold, step_cnt, busy, done
   );
endinterface

// File: rtl/agent_scheduler.sv
// agent_scheduler: sequences sense -> decide -> act -> update for one intersection's Q-learning agent.
module agent_scheduler #(
   parameter int          L_WIDTH    = 4,
   parameter int          T_UNIT     = 8,
   parameter int          STEP_WIDTH = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input logic               clk,
   input logic               rst,
   agent_scheduler_if.slave  bus
);
   localparam int A_DUR_WIDTH = L_WIDTH / 2;
   localparam int A_WIDTH     = 2 + A_DUR_WIDTH;
   localparam int TW          = $clog2((2 ** A_DUR_WIDTH) * T_UNIT);

   typedef enum logic [2:0] {
      S_IDLE, S_SENSE, S_DECIDE, S_LATCH, S_EXEC, S_OBSERVE, S_UPDATE, S_FIN
   } state_t;

   state_t                r_state;
   logic [15:0]           r_lfsr;
   logic [TW-1:0]         r_timer;
   logic                  r_stop_pend;
   logic                  r_a_sel;
   logic                  r_mode;
   logic                  r_agent_en;
   logic                  r_q_wr;
   logic                  r_light_go;
   logic [A_WIDTH-1:0]    r_a_hold;
   logic [STEP_WIDTH-1:0] r_step_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic [15:0]           w_lfsr_nxt;
   logic [TW-1:0]         w_load;
   logic                  w_end;

   assign w_lfsr_nxt = r_lfsr[0] ? (r_lfsr >> 1) ^ 16'hB400 : r_lfsr >> 1;
   // Green time spans (dur+1) whole units; timer counts down to 0 inclusive.
   assign w_load = TW'((int'(bus.A[A_DUR_WIDTH-1:0]) + 1) * T_UNIT - 1);
   assign w_end  = r_stop_pend ||
                   (bus.max_step != '0 && r_step_cnt + STEP_WIDTH'(1) == bus.max_step);

   // Strobes are registered: each is set on the transition into the state it marks.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_lfsr      <= LFSR_SEED;
         r_timer     <= '0;
         r_stop_pend <= 1'b0;
         r_a_sel     <= 1'b0;
         r_mode      <= 1'b0;
         r_agent_en  <= 1'b0;
         r_q_wr      <= 1'b0;
         r_light_go  <= 1'b0;
         r_a_hold    <= '0;
         r_step_cnt  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_lfsr     <= w_lfsr_nxt;
         r_agent_en <= 1'b0;
         r_q_wr     <= 1'b0;
         r_done     <= 1'b0;
         if (bus.stop && r_state != S_IDLE) r_stop_pend <= 1'b1;
         case (r_state)
            S_IDLE: if (bus.start) begin
               r_mode      <= bus.learn;
               r_step_cnt  <= '0;
               r_stop_pend <= 1'b0;
               r_busy      <= 1'b1;
               r_state     <= S_SENSE;
            end
            S_SENSE: if (bus.sensor_valid) begin
               r_agent_en <= 1'b1;
               r_state    <= S_DECIDE;
            end
            S_DECIDE: begin
               r_a_sel <= r_lfsr[7:0] < bus.epsilon;
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_a_hold   <= bus.A;
               r_timer    <= w_load;
               r_light_go <= 1'b1;
               r_state    <= S_EXEC;
            end
            S_EXEC: if (r_timer == '0) begin
               r_light_go <= 1'b0;
               r_state    <= S_OBSERVE;
            end else begin
               r_timer <= r_timer - TW'(1);
            end
            S_OBSERVE: if (bus.sensor_valid) begin
               r_q_wr  <= r_mode;
               r_state <= S_UPDATE;
            end
            S_UPDATE: begin
               r_step_cnt <= r_step_cnt + STEP_WIDTH'(1);
               r_done     <= w_end;
               r_agent_en <= !w_end;
               r_state    <= w_end ? S_FIN : S_DECIDE;
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy     <= 1'b0;
               r_light_go <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.A_sel    = r_a_sel;
   assign bus.mode     = r_mode;
   assign bus.agent_en = r_agent_en;
   assign bus.q_wr     = r_q_wr;
   assign bus.light_go = r_light_go;
   assign bus.a_hold   = r_a_hold;
   assign bus.step_cnt = r_step_cnt;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
endmodule

// File: tb/tb_agent_scheduler.sv
// tb_agent_scheduler: table-driven episodes plus scoreboarded A_sel / green-time checks against a reference LFSR.
module tb_agent_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   agent_scheduler_if #(.L_WIDTH(4), .STEP_WIDTH(16)) bus ();
   agent_scheduler #(.L_WIDTH(4), .T_UNIT(8), .STEP_WIDTH(16), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   logic [15:0] m_lfsr;
   always @(posedge clk)
      m_lfsr <= !rst ? 16'hACE1 : (m_lfsr[0] ? (m_lfsr >> 1) ^ 16'hB400 : m_lfsr >> 1);

   typedef struct {
      logic        learn;
      logic [15:0] max;
      logic [7:0]  eps;
      logic [3:0]  a;
      int          exp_steps;
      int          exp_qwr;
   } vec_t;
   vec_t vecs[6];

   int n_vec = 0, n_err = 0, cyc = 0;
   int n_qwr, n_done, n_light, n_asel1, last_en, run;
   int done_step;
   logic done_busy;
   bit prev_en;
   bit sb_asel[$];
   int sb_len[$];
   int gaps[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic clr_ep();
      n_qwr = 0; n_done = 0; n_light = 0; n_asel1 = 0; last_en = -1;
      gaps.delete();
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (prev_en) begin
         if (sb_asel.size() > 0) chk("a_sel", 32'(bus.A_sel), 32'(sb_asel.pop_front()));
         sb_len.push_back((int'(bus.A[1:0]) + 1) * 8);
         if (bus.A_sel) n_asel1++;
      end
      if (bus.agent_en) begin
         sb_asel.push_back(m_lfsr[7:0] < bus.epsilon);
         if (last_en >= 0) gaps.push_back(cyc - last_en);
         last_en = cyc;
      end
      prev_en = bus.agent_en;
      if (bus.light_go) begin
         if (run == 0) chk("a_hold", 32'(bus.a_hold), 32'(bus.A));
         run++;
      end else if (run != 0) begin
         if (sb_len.size() > 0) chk("light_len", run, sb_len.pop_front());
         n_light++;
         run = 0;
      end
      if (bus.q_wr) n_qwr++;
      if (bus.done) begin
         n_done++;
         done_step = int'(bus.step_cnt);
         done_busy = bus.busy;
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20000 && n_done == 0; i++) tick();
      if (n_done == 0) chk("done_timeout", 0, 1);
   endtask

   task automatic run_row(input vec_t v);
      bus.learn = v.learn; bus.max_step = v.max; bus.epsilon = v.eps; bus.A = v.a;
      bus.sensor_valid = 1'b1;
      clr_ep();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done();
      tick();
      chk("done_step", done_step, v.exp_steps);
      chk("done_busy", 32'(done_busy), 1);
      chk("busy_after", 32'(bus.busy), 0);
      chk("n_done", n_done, 1);
      chk("n_qwr", n_qwr, v.exp_qwr);
      chk("n_light", n_light, v.exp_steps);
      chk("mode", 32'(bus.mode), 32'(v.learn));
      chk("n_gaps", gaps.size(), v.exp_steps - 1);
      while (gaps.size() > 0) chk("step_gap", gaps.pop_front(), (int'(v.a[1:0]) + 1) * 8 + 4);
      if (v.eps == 8'd0) chk("asel_eps0", n_asel1, 0);
   endtask

   task automatic chk_reset_outs();
      chk("rst_light_go", 32'(bus.light_go), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_a_hold", 32'(bus.a_hold), 0);
      chk("rst_step_cnt", 32'(bus.step_cnt), 0);
      chk("rst_a_sel", 32'(bus.A_sel), 0);
      chk("rst_mode", 32'(bus.mode), 0);
      chk("rst_q_wr", 32'(bus.q_wr), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_agent_en", 32'(bus.agent_en), 0);
   endtask

   initial begin
      vecs[0] = '{1'b1, 16'd3,  8'd128, 4'b0001, 3,  3};
      vecs[1] = '{1'b0, 16'd2,  8'd200, 4'b0011, 2,  0};
      vecs[2] = '{1'b1, 16'd1,  8'd255, 4'b1100, 1,  1};
      vecs[3] = '{1'b1, 16'd50, 8'd0,   4'b0010, 50, 50};
      vecs[4] = '{1'b1, 16'd40, 8'd255, 4'b0000, 40, 40};
      vecs[5] = '{1'b0, 16'd4,  8'd64,  4'b1001, 4,  0};
      bus.start = 1'b0; bus.stop = 1'b0; bus.learn = 1'b0; bus.max_step = '0;
      bus.epsilon = '0; bus.sensor_valid = 1'b0; bus.A = '0;
      prev_en = 1'b0; run = 0;
      clr_ep();
      repeat (3) @(negedge clk);
      chk_reset_outs();
      rst = 1'b1;
      foreach (vecs[k]) run_row(vecs[k]);

      // Reset in the middle of a green phase
      bus.learn = 1'b1; bus.max_step = '0; bus.epsilon = 8'd90; bus.A = 4'b0010;
      bus.sensor_valid = 1'b1;
      clr_ep();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2000 && !(bus.step_cnt == 16'd2 && bus.light_go); i++) tick();
      chk("reach_exec", 32'(bus.light_go), 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      sb_asel.delete(); sb_len.delete(); run = 0; prev_en = 1'b0;
      chk_reset_outs();
      tick();
      chk("rst_stays_idle", 32'(bus.busy), 0);
      run_row(vecs[0]);

      // Early stop during step 5 of an unlimited episode; start while busy ignored
      bus.learn = 1'b1; bus.max_step = '0; bus.epsilon = 8'd128; bus.A = 4'b0001;
      clr_ep();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2000 && !(bus.step_cnt == 16'd4 && bus.light_go); i++) tick();
      chk("reach_step5", 32'(bus.light_go), 1);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      bus.start = 1'b1; bus.learn = 1'b0;
      tick();
      bus.start = 1'b0; bus.learn = 1'b1;
      wait_done();
      tick();
      chk("stop_step", done_step, 5);
      chk("stop_qwr", n_qwr, 5);
      chk("stop_ndone", n_done, 1);
      chk("stop_mode", 32'(bus.mode), 1);
      chk("stop_busy", 32'(bus.busy), 0);
      repeat (3) tick();
      chk("stop_idle", 32'(bus.busy), 0);

      // sensor_valid held low in OBSERVE
      bus.learn = 1'b1; bus.max_step = 16'd1; bus.epsilon = 8'd50; bus.A = 4'b0000;
      clr_ep();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 100 && !bus.light_go; i++) tick();
      bus.sensor_valid = 1'b0;
      for (int i = 0; i < 100 && bus.light_go; i++) tick();
      chk("obs_light_off", 32'(bus.light_go), 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("obs_q_wr", 32'(bus.q_wr), 0);
         chk("obs_step", 32'(bus.step_cnt), 0);
      end
      bus.sensor_valid = 1'b1;
      tick();
      chk("obs_update_qwr", 32'(bus.q_wr), 1);
      tick();
      chk("obs_done", 32'(bus.done), 1);
      chk("obs_step_done", 32'(bus.step_cnt), 1);
      tick();
      chk("obs_busy", 32'(bus.busy), 0);
      chk("obs_nqwr", n_qwr, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/agent_scheduler.md
Name: agent_scheduler

Overview:
Sequences the Q-learning AGENT through its sense -> decide -> act -> update loop for one intersection. Draws the explore/exploit choice (A_sel) from an internal LFSR against an epsilon threshold and holds the chosen action for a duration-derived green time. Pulses the Q-table write once per step and counts steps until the episode limit or a stop request. Sits between the sensor front-end, the AGENT datapath and the light driver.

Parameters:
L_WIDTH, 4, state level width; A_DUR_WIDTH = L_WIDTH/2, A_WIDTH = 2 + A_DUR_WIDTH
T_UNIT, 8, clock cycles per action-duration unit
STEP_WIDTH, 16, width of step counter and max_step
LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-low reset
start  in  1  begin episode; sampled only in IDLE
stop  in  1  request early end; honoured at next UPDATE
learn  in  1  1 = learning episode; sampled into mode at start
max_step  in  STEP_WIDTH  steps per episode; 0 = unlimited
epsilon  in  8  explore threshold
sensor_valid  in  1  new road-level sample present
A  in  A_WIDTH  action from AGENT, valid the cycle after agent_en
A_sel  out  1  1 = random action, 0 = greedy; held per step
mode  out  1  learn value latched at start
agent_en  out  1  one-cycle decide strobe to AGENT
q_wr  out  1  one-cycle Q write strobe (only when mode=1)
light_go  out  1  high while the action is applied
a_hold  out  A_WIDTH  latched action driving the lights
step_cnt  out  STEP_WIDTH  completed steps this episode
busy  out  1  high in any state but IDLE
done  out  1  one-cycle end-of-episode pulse

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; LFSR = LFSR_SEED; timer 0; stop_pend 0. Overrides every state, including mid-EXECUTE.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle when rst=1.
- FSM states:
  - IDLE: on start=1, latch mode<=learn, clear step_cnt and stop_pend, go to SENSE. start while busy is ignored.
  - SENSE: wait for sensor_valid=1, then go to DECIDE.
  - DECIDE (1 cycle): agent_en=1; A_sel <= (lfsr[7:0] < epsilon). Go to LATCH.
  - LATCH (1 cycle): a_hold <= A; timer <= (A[A_DUR_WIDTH-1:0]+1)*T_UNIT - 1. Go to EXEC.
  - EXEC: light_go=1; timer decrements each cycle; leave after the timer=0 cycle. light_go is high for exactly (dur+1)*T_UNIT cycles. Go to OBSERVE.
  - OBSERVE: wait for sensor_valid=1 (next state for the Q update), then go to UPDATE.
  - UPDATE (1 cycle): q_wr=mode; step_cnt increments. Go to FIN if stop_pend, or if max_step!=0 and step_cnt+1==max_step; otherwise go to DECIDE (the observed state is reused; no SENSE).
  - FIN (1 cycle): done=1, busy still 1. Go to IDLE.
- stop: a stop=1 in any busy cycle sets stop_pend. The current step always completes through UPDATE.
- Boundary values:
  - epsilon=0: A_sel always 0.
  - epsilon=255: A_sel=0 only when lfsr[7:0]=255.
  - max_step=0: the episode ends only on stop.
  - max_step=1: exactly one step.
- step_cnt wraps modulo 2^STEP_WIDTH in unlimited mode.
- a_hold and A_sel hold their values between steps and in IDLE after an episode, until reset or the next LATCH/DECIDE.
- Minimum step latency: sensor_valid held high, dur=0, T_UNIT=8 -> DECIDE to the next DECIDE is 12 cycles (DECIDE, LATCH, 8 EXEC, OBSERVE, UPDATE).

Test Plan:
- Reset mid-EXEC: drive rst=0 for 1 cycle -> next cycle state IDLE; light_go, busy, a_hold, step_cnt all 0; LFSR = 16'hACE1.
- max_step=3, learn=1, sensor_valid=1, A=4'b0001 -> light_go high 16 cycles per step; 3 q_wr pulses; done pulses once with step_cnt=3; busy falls the cycle after done.
- learn=0, max_step=2 -> q_wr never asserts; step_cnt reaches 2; done pulses once.
- epsilon=0 over 50 steps -> A_sel always 0. epsilon=255 -> A_sel=1 except when lfsr[7:0]=255, checked against a reference LFSR model.
- max_step=0, stop pulsed during step 5's EXEC -> step 5 completes with q_wr; done follows; step_cnt=5; start raised while busy has no effect.
- sensor_valid held low in OBSERVE for 20 cycles -> FSM waits with no q_wr and no step_cnt change; update occurs 1 cycle after sensor_valid rises.
